// File: rtl/prio_heap_queue_if.sv
// Command/response bundle for the heap priority queue.
// The master side issues commands; the slave side (the queue) answers and reports status.
interface prio_heap_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [4:0]        cmd_rd;
    logic [DATA_W-1:0] cmd_data;
    logic              out_v;
    logic [4:0]        out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_data,
        input  cmd_ready, out_v, out_rd, out_data, out_err, count, full, empty
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_data,
        output cmd_ready, out_v, out_rd, out_data, out_err, count, full, empty
    );
endinterface

// File: rtl/prio_heap_queue.sv
// Binary-heap priority queue: PUSH / POP / PEEK / REPLACE with one registered response per
// accepted command. Re-heapification is done one compare/swap per cycle while cmd_ready is low.
module prio_heap_queue #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 25,
    parameter bit          MIN_HEAP = 1'b0,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    prio_heap_queue_if.slave bus
);
    // Index math is one bit wider than count so 2*idx+2 never wraps.
    localparam int unsigned IW = CNT_W + 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] OpPush    = 2'b00;
    localparam logic [1:0] OpPop     = 2'b01;
    localparam logic [1:0] OpPeek    = 2'b10;
    localparam logic [1:0] OpReplace = 2'b11;

    typedef enum logic [1:0] {StIdle, StSiftUp, StSiftDown} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_v_q, out_v_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Up to two storage writes per cycle (a swap needs both).
    logic              we_a, we_b;
    logic [AW-1:0]     wa_a, wa_b;
    logic [DATA_W-1:0] wd_a, wd_b;

    logic [IW-1:0]     cnt_ext;
    logic [IW-1:0]     parent, lchild, rchild, best;

    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MIN_HEAP) begin
            return a < b;
        end
        return a > b;
    endfunction

    assign cnt_ext = {1'b0, count_q};

    // Neighbour indices and the best of {idx, left, right} for the sift-down step.
    always_comb begin
        parent = (idx_q - IW'(1)) >> 1;
        lchild = (idx_q << 1) + IW'(1);
        rchild = (idx_q << 1) + IW'(2);
        best   = idx_q;
        if (lchild < cnt_ext && better(mem_q[AW'(lchild)], mem_q[AW'(best)])) begin
            best = lchild;
        end
        // Strictly better only, so the left child keeps ties.
        if (rchild < cnt_ext && better(mem_q[AW'(rchild)], mem_q[AW'(best)])) begin
            best = rchild;
        end
    end

    // Next-state, response and storage-write decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        out_v_d    = 1'b0;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        we_a       = 1'b0;
        wa_a       = '0;
        wd_a       = '0;
        we_b       = 1'b0;
        wa_b       = '0;
        wd_b       = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    out_v_d    = 1'b1;
                    out_rd_d   = bus.cmd_rd;
                    out_data_d = '0;
                    out_err_d  = 1'b0;
                    unique case (bus.cmd_op)
                        OpPush: begin
                            if (count_q == CNT_W'(DEPTH)) begin
                                out_err_d = 1'b1;
                            end else begin
                                we_a    = 1'b1;
                                wa_a    = AW'(count_q);
                                wd_a    = bus.cmd_data;
                                count_d = count_q + CNT_W'(1);
                                if (count_q != '0) begin
                                    state_d = StSiftUp;
                                    idx_d   = cnt_ext;
                                end
                            end
                        end
                        OpPop: begin
                            if (count_q == '0) begin
                                out_err_d = 1'b1;
                            end else begin
                                out_data_d = mem_q[0];
                                we_a       = 1'b1;
                                wa_a       = '0;
                                wd_a       = mem_q[AW'(count_q - CNT_W'(1))];
                                count_d    = count_q - CNT_W'(1);
                                if (count_q > CNT_W'(2)) begin
                                    state_d = StSiftDown;
                                    idx_d   = '0;
                                end
                            end
                        end
                        OpPeek: begin
                            if (count_q == '0) begin
                                out_err_d = 1'b1;
                            end else begin
                                out_data_d = mem_q[0];
                            end
                        end
                        OpReplace: begin
                            if (count_q == '0) begin
                                out_err_d = 1'b1;
                            end else begin
                                out_data_d = mem_q[0];
                                we_a       = 1'b1;
                                wa_a       = '0;
                                wd_a       = bus.cmd_data;
                                if (count_q > CNT_W'(1)) begin
                                    state_d = StSiftDown;
                                    idx_d   = '0;
                                end
                            end
                        end
                    endcase
                end
            end
            StSiftUp: begin
                if (idx_q != '0 && better(mem_q[AW'(idx_q)], mem_q[AW'(parent)])) begin
                    we_a  = 1'b1;
                    wa_a  = AW'(idx_q);
                    wd_a  = mem_q[AW'(parent)];
                    we_b  = 1'b1;
                    wa_b  = AW'(parent);
                    wd_b  = mem_q[AW'(idx_q)];
                    idx_d = parent;
                end else begin
                    state_d = StIdle;
                end
            end
            StSiftDown: begin
                if (best != idx_q) begin
                    we_a  = 1'b1;
                    wa_a  = AW'(idx_q);
                    wd_a  = mem_q[AW'(best)];
                    we_b  = 1'b1;
                    wa_b  = AW'(best);
                    wd_b  = mem_q[AW'(idx_q)];
                    idx_d = best;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers; reset abandons any sift and empties the heap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            count_q    <= '0;
            out_v_q    <= 1'b0;
            out_rd_q   <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            out_v_q    <= out_v_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    // Element storage; contents are meaningless beyond count, so no reset.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_q[wa_a] <= wd_a;
        end
        if (we_b) begin
            mem_q[wa_b] <= wd_b;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.out_v     = out_v_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == CNT_W'(DEPTH));
    assign bus.empty     = (count_q == '0);
endmodule

// File: doc/prio_heap_queue.md
Name: prio_heap_queue

Overview:
- Parametrised successor of the single-width max-heap custom SIMD instruction unit: binary-heap priority queue with configurable data width, depth and min/max ordering.
- Adds explicit valid/ready command handshake, PEEK and REPLACE operations, full/empty/count status and error reporting.
- Sits behind the custom-instruction decode, and returns one response per accepted command.

Parameters:
- DATA_W, 32, element width in bits, unsigned compare.
- DEPTH, 25, maximum number of stored elements, minimum 2.
- MIN_HEAP, 0, 0 = root is largest (max-heap), 1 = root is smallest (min-heap).
- CNT_W, $clog2(DEPTH+1), width of the count output (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command; equals (state==IDLE).
- cmd_op  in  2  00 PUSH, 01 POP, 10 PEEK, 11 REPLACE.
- cmd_rd  in  5  destination tag, echoed on the response.
- cmd_data  in  DATA_W  operand for PUSH and REPLACE.
- out_v  out  1  one-cycle response strobe.
- out_rd  out  5  echoed cmd_rd.
- out_data  out  DATA_W  root value before the operation; 0 for PUSH or on error.
- out_err  out  1  command rejected (overflow or underflow).
- count  out  CNT_W  current number of elements.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset (sampled at posedge clk):
  - state=IDLE, count=0.
  - out_v=0, out_rd=0, out_data=0, out_err=0.
  - Storage contents need not be cleared.
  - Reset overrides any in-flight sift: the operation is abandoned and the heap is empty afterwards.
- Accept: a command is accepted at the rising edge where cmd_valid && cmd_ready. cmd_ready is low in the sift states, and commands are held off there.
- Ordering predicate better(a,b):
  - a>b when MIN_HEAP=0, a<b when MIN_HEAP=1.
  - Equal values are never swapped.
- Response timing:
  - out_v is registered high for exactly one cycle, in the cycle after accept, for every accepted op, including errors.
  - out_rd is updated at the same edge.
  - out_v is 0 in all other cycles.
- PUSH:
  - If full: out_err=1, heap unchanged, stay IDLE.
  - Otherwise: write mem[count]=cmd_data, count+1, out_data=0.
  - If the old count was 0, stay IDLE; else go to SIFT_UP with idx=old count.
- POP:
  - If empty: out_err=1, out_data=0, heap unchanged.
  - Otherwise: out_data=mem[0], mem[0]=mem[count-1], count-1.
  - If the new count is 0 or 1, stay IDLE; else go to SIFT_DOWN with idx=0.
- PEEK:
  - If empty: out_err=1, out_data=0.
  - Otherwise: out_data=mem[0].
  - Heap and count unchanged; stays IDLE, so back-to-back PEEKs are accepted every cycle.
- REPLACE:
  - If empty: out_err=1, heap unchanged.
  - Otherwise: out_data=mem[0], mem[0]=cmd_data, count unchanged.
  - Go to SIFT_DOWN if count>1, else stay IDLE.
- SIFT_UP (one compare/swap per cycle):
  - parent=(idx-1)>>1.
  - If idx>0 && better(mem[idx],mem[parent]): swap, idx=parent.
  - Else go to IDLE.
- SIFT_DOWN (one compare/swap per cycle):
  - Compute best of idx, 2idx+1, 2idx+2, considering only children < count; the left child wins ties against the right.
  - If best!=idx: swap, idx=best.
  - Else go to IDLE.
- Latency: busy cycles after accept are at most floor(log2(DEPTH))+1. cmd_ready returns high in the cycle after the terminating compare.
- Index arithmetic is done at CNT_W+1 bits so 2idx+2 cannot wrap.
- Status outputs count/full/empty are registered and reflect the post-operation count from the accept edge onward.
- Invariant: whenever state==IDLE, the heap property holds over mem[0..count-1].

Test Plan:
- Reset, then PUSH 5,17,3,42,8 (MIN_HEAP=0) -> each response out_v=1, out_err=0, out_data=0; final count=5, PEEK returns 42, cmd_ready high throughout the PEEK.
- Five POPs from that state -> out_data 42,17,8,5,3 in order; then a sixth POP -> out_err=1, out_data=0, empty=1.
- MIN_HEAP=1, DEPTH=4: PUSH 9,2,7,4 -> full=1; PUSH 1 -> out_err=1, count stays 4; POP -> out_data=2.
- REPLACE 1 on max-heap {42,17,8} -> out_data=42, count=3, next PEEK returns 17; REPLACE on an empty heap -> out_err=1.
- Duplicates: PUSH 6,6,6 then POP x3 -> out_data 6,6,6; cmd_rd=13 on each command echoes out_rd=13.
- Assert reset during SIFT_DOWN following a POP on a 7-element heap -> next cycle count=0, empty=1, out_v=0, cmd_ready=1.
